// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for 7-segment display users: digit count, the "all off"
// patterns for the active-low digit selects and active-high segments, and the
// hex segment codes ({a,b,c,d,e,f,g} on bits [6:0]).
// Also provides a helper that builds the one-cold digit select for an index.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package seg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_OFF    = 7'b0000000;
    localparam logic [7:0] DIGIT_OFF  = 8'hFF;

    localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
    localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
    localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
    localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1111011;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b0011111;
    localparam logic [6:0] SEG_HEX_C = 7'b1001110;
    localparam logic [6:0] SEG_HEX_D = 7'b0111101;
    localparam logic [6:0] SEG_HEX_E = 7'b1001111;
    localparam logic [6:0] SEG_HEX_F = 7'b1000111;

    // Active-low select: all ones except the bit for the addressed digit.
    function automatic logic [7:0] digit_select(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to 7-segment code, active-high segments.
// Ports:
//   nibble_i  4-bit hex value
//   seg_o     segment code {a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Hex lookup into the shared segment code table.
    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0:    seg_o = SEG_HEX_0;
            4'h1:    seg_o = SEG_HEX_1;
            4'h2:    seg_o = SEG_HEX_2;
            4'h3:    seg_o = SEG_HEX_3;
            4'h4:    seg_o = SEG_HEX_4;
            4'h5:    seg_o = SEG_HEX_5;
            4'h6:    seg_o = SEG_HEX_6;
            4'h7:    seg_o = SEG_HEX_7;
            4'h8:    seg_o = SEG_HEX_8;
            4'h9:    seg_o = SEG_HEX_9;
            4'hA:    seg_o = SEG_HEX_A;
            4'hB:    seg_o = SEG_HEX_B;
            4'hC:    seg_o = SEG_HEX_C;
            4'hD:    seg_o = SEG_HEX_D;
            4'hE:    seg_o = SEG_HEX_E;
            4'hF:    seg_o = SEG_HEX_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexes eight hex digits onto a common-select 7-segment display.
// The digit values, blank flags and leading-zero enable are captured into a
// shadow buffer once per frame (slot 0, count 0) so a frame never tears.
// Each slot begins with GUARD dark cycles to prevent ghosting.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   digits_i   digit d value in digits_i[4d+3:4d], d=0 rightmost
//   blank_i    bit d forces digit d dark
//   lz_en_i    enables leading-zero suppression
//   frame_o    one-cycle pulse after the shadow-buffer load edge
//   DIGIT      active-low digit selects, at most one low
//   SEG        active-high segments {a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits_i,
    input  logic [7:0]  blank_i,
    input  logic        lz_en_i,
    output logic        frame_o,
    output logic [7:0]  DIGIT,
    output logic [6:0]  SEG
);

    localparam int            CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_digits_q;
    logic [7:0]    shadow_blank_q;
    logic          shadow_lz_q;
    logic          frame_q;
    logic [7:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;

    logic          load_s;
    logic          guard_s;
    logic          dark_s;
    logic [7:0]    supp_s;
    logic          above_ok_s;
    logic          nib_zero_s;
    logic [3:0]    nibble_s;
    logic [6:0]    seg_code_s;

    assign load_s   = (cnt_q == '0) && (idx_q == 3'd0);
    assign guard_s  = int'(cnt_q) < GUARD;
    assign nibble_s = shadow_digits_q[{idx_q, 2'b00} +: 4];
    assign dark_s   = shadow_blank_q[idx_q] | supp_s[idx_q];

    seg7_decode u_decode (
        .nibble_i (nibble_s),
        .seg_o    (seg_code_s)
    );

    // Slot counter and digit index advance.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end
    end

    // Leading-zero suppression, scanning from the top digit down; a digit above
    // that is either zero or blanked keeps the run of leading zeros alive.
    always_comb begin
        above_ok_s = 1'b1;
        nib_zero_s = 1'b0;
        supp_s     = 8'b0000_0000;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            nib_zero_s = (shadow_digits_q[4*d +: 4] == 4'h0);
            supp_s[d]  = shadow_lz_q & above_ok_s & nib_zero_s;
            above_ok_s = above_ok_s & (nib_zero_s | shadow_blank_q[d]);
        end
    end

    // Next display outputs from the current (pre-edge) slot state.
    always_comb begin
        if (guard_s || dark_s) begin
            digit_d = DIGIT_OFF;
            seg_d   = SEG_OFF;
        end else begin
            digit_d = digit_select(idx_q);
            seg_d   = seg_code_s;
        end
    end

    // Scan state, frame-synchronous shadow buffer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q           <= '0;
            idx_q           <= 3'd0;
            shadow_digits_q <= 32'h0000_0000;
            shadow_blank_q  <= 8'hFF;
            shadow_lz_q     <= 1'b0;
            frame_q         <= 1'b0;
            digit_q         <= DIGIT_OFF;
            seg_q           <= SEG_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= load_s;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            if (load_s) begin
                shadow_digits_q <= digits_i;
                shadow_blank_q  <= blank_i;
                shadow_lz_q     <= lz_en_i;
            end else begin
                shadow_digits_q <= shadow_digits_q;
                shadow_blank_q  <= shadow_blank_q;
                shadow_lz_q     <= shadow_lz_q;
            end
        end
    end

    assign frame_o = frame_q;
    assign DIGIT   = digit_q;
    assign SEG     = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        lz_en;
    logic        frame;
    logic [7:0]  digit_sel;
    logic [6:0]  seg;

    seg_scan_driver #(.SCAN_DIV(8), .GUARD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .digits_i (digits),
        .blank_i  (blank),
        .lz_en_i  (lz_en),
        .frame_o  (frame),
        .DIGIT    (digit_sel),
        .SEG      (seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dig;
        logic [6:0] seg;
        logic       frm;
        logic [7:0] phase;
        logic [2:0] slot;
        logic [2:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] phase  = 8'd0;
    logic [6:0] hex_tbl [16];

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Queue the expected outputs for n edges of one slot (2 guard cycles then lit).
    task automatic push_slot(input int slot, input logic lit, input logic [6:0] s, input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.phase = phase;
            e.slot  = 3'(slot);
            e.cnt   = 3'(c);
            e.frm   = (slot == 0) && (c == 0);
            if (lit && c >= 2) begin
                e.dig = ~(8'h01 << slot);
                e.seg = s;
            end else begin
                e.dig = 8'hFF;
                e.seg = 7'b0000000;
            end
            sb_q.push_back(e);
        end
    endtask

    // Advance n edges, comparing each against the head of the scoreboard.
    task automatic drain(input int n);
        exp_t  e;
        string t;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                cmp("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                t = $sformatf("p%0d_s%0d_c%0d", e.phase, e.slot, e.cnt);
                cmp({t, "_DIGIT"}, {24'h0, digit_sel}, {24'h0, e.dig});
                cmp({t, "_SEG"},   {25'h0, seg},       {25'h0, e.seg});
                cmp({t, "_frame"}, {31'h0, frame},     {31'h0, e.frm});
            end
        end
    endtask

    initial begin
        hex_tbl[0]  = 7'b1111110; hex_tbl[1]  = 7'b0110000;
        hex_tbl[2]  = 7'b1101101; hex_tbl[3]  = 7'b1111001;
        hex_tbl[4]  = 7'b0110011; hex_tbl[5]  = 7'b1011011;
        hex_tbl[6]  = 7'b1011111; hex_tbl[7]  = 7'b1110000;
        hex_tbl[8]  = 7'b1111111; hex_tbl[9]  = 7'b1111011;
        hex_tbl[10] = 7'b1110111; hex_tbl[11] = 7'b0011111;
        hex_tbl[12] = 7'b1001110; hex_tbl[13] = 7'b0111101;
        hex_tbl[14] = 7'b1001111; hex_tbl[15] = 7'b1000111;

        // Reset held low for 30 ns; outputs must stay dark throughout.
        rst    = 1'b0;
        digits = 32'h7654_3210;
        blank  = 8'h00;
        lz_en  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmp("reset_DIGIT", {24'h0, digit_sel}, 32'h0000_00FF);
            cmp("reset_SEG",   {25'h0, seg},       32'h0);
            cmp("reset_frame", {31'h0, frame},     32'h0);
        end
        rst = 1'b1;

        // Basic scan of 76543210.
        phase = 8'd1;
        for (int s = 0; s < 8; s++) push_slot(s, 1'b1, hex_tbl[s], 8);
        drain(64);

        // Leading-zero suppression on 00000805.
        digits = 32'h0000_0805;
        lz_en  = 1'b1;
        phase  = 8'd2;
        push_slot(0, 1'b1, hex_tbl[5], 8);
        push_slot(1, 1'b1, hex_tbl[0], 8);
        push_slot(2, 1'b1, hex_tbl[8], 8);
        for (int s = 3; s < 8; s++) push_slot(s, 1'b0, 7'b0000000, 8);
        drain(64);

        // Blank flag and hex F decode.
        digits = 32'h0000_00F3;
        blank  = 8'h01;
        lz_en  = 1'b0;
        phase  = 8'd3;
        push_slot(0, 1'b0, 7'b0000000, 8);
        push_slot(1, 1'b1, hex_tbl[15], 8);
        for (int s = 2; s < 8; s++) push_slot(s, 1'b1, hex_tbl[0], 8);
        drain(64);

        // Double buffering: mid-frame input change is held off until next load.
        digits = 32'h1111_1111;
        blank  = 8'h00;
        phase  = 8'd4;
        for (int s = 0; s < 8; s++) push_slot(s, 1'b1, hex_tbl[1], 8);
        drain(20);
        digits = 32'h2222_2222;
        drain(44);
        phase = 8'd5;
        for (int s = 0; s < 3; s++) push_slot(s, 1'b1, hex_tbl[2], 8);
        push_slot(3, 1'b1, hex_tbl[2], 4);
        drain(28);

        // Asynchronous reset in the middle of slot 3.
        #2;
        rst = 1'b0;
        #1;
        cmp("midreset_DIGIT", {24'h0, digit_sel}, 32'h0000_00FF);
        cmp("midreset_SEG",   {25'h0, seg},       32'h0);
        cmp("midreset_frame", {31'h0, frame},     32'h0);
        @(negedge clk);
        cmp("midreset_hold_DIGIT", {24'h0, digit_sel}, 32'h0000_00FF);
        @(negedge clk);
        rst    = 1'b1;
        digits = 32'h7654_3210;
        phase  = 8'd6;
        push_slot(0, 1'b1, hex_tbl[0], 8);
        push_slot(1, 1'b1, hex_tbl[1], 8);
        drain(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the vending machine.
- Takes eight 4-bit hex digit values plus per-digit blank flags from the controller and time-multiplexes them onto the 8-digit common-select 7-segment display through DIGIT/SEG.
- Provides frame-synchronous double buffering, an anti-ghosting guard interval and optional leading-zero suppression.
- Replaces ad-hoc scanning inside the controller.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot; legal range 2 or more.
- GUARD, 16: cycles at the start of each slot with all digits off; legal range 0 to SCAN_DIV-1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- digits_i  input  32  hex value of digit d in digits_i[4d+3:4d]; d=0 is rightmost
- blank_i  input  8  bit d=1 forces digit d dark
- lz_en_i  input  1  enables leading-zero suppression
- frame_o  output  1  one-cycle pulse on the edge that loads the shadow buffer
- DIGIT  output  8  digit selects, active-low; at most one bit low
- SEG  output  7  segments active-high, {a,b,c,d,e,f,g} on SEG[6:0]

Behaviour:
- State registers:
  - cnt, 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - idx, 0..7.
  - shadow_digits (32 bits), shadow_blank (8 bits), shadow_lz (1 bit).
- Reset (rst low, asynchronous):
  - cnt=0, idx=0.
  - shadow_digits=0, shadow_blank=8'hFF, shadow_lz=0.
  - DIGIT=8'hFF, SEG=7'b0000000, frame_o=0.
- Counting:
  - Each edge: cnt increments.
  - At cnt==SCAN_DIV-1: cnt returns to 0 and idx increments; idx wraps 7 to 0.
- Frame load:
  - On every edge where state is (cnt==0, idx==0), sample digits_i, blank_i and lz_en_i into the shadow registers.
  - frame_o is 1 for exactly the cycle following that edge.
  - The first load occurs on the first edge after reset release.
  - Input changes at any other time have no visible effect until the next load.
- Output pipeline: DIGIT, SEG and frame_o are registered, one cycle behind (cnt, idx).
- Slot rules, evaluated on pre-edge state:
  - cnt<GUARD: DIGIT=8'hFF, SEG=0.
  - Else if digit idx is dark: DIGIT=8'hFF, SEG=0.
  - Else: DIGIT = all ones except bit idx = 0; SEG = decode(shadow nibble idx).
- Dark condition for digit idx: shadow_blank[idx]=1, or the digit is lz-suppressed.
- LZ suppression, only when shadow_lz=1 and only for idx 7..1:
  - Digit d is suppressed if its nibble is 0 and every digit above d is either zero or blanked.
  - Digit 0 is never suppressed.
- Decode (hex): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Timing:
  - Frame length is 8*SCAN_DIV cycles.
  - A slot is lit for SCAN_DIV-GUARD cycles.
  - With GUARD=0, adjacent digits switch on the same edge with no dark gap.
- Reset mid-scan: outputs go dark immediately (asynchronously), the scan restarts at idx 0, and the next load occurs on the first edge after release.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS=8.
  - SEG_OFF=7'b0000000, DIGIT_OFF=8'hFF.
  - The 16 hex segment-code constants.
- Sub-module seg7_decode: combinational 4-bit to 7-bit decode using seg_pkg constants. It is shared with any other display user in the design.

Test Plan:
- All scenarios use SCAN_DIV=8 and GUARD=2.
- Reset: hold rst low for 30 ns. Required: DIGIT=8'hFF, SEG=0, frame_o=0 throughout; first two edges after release remain dark; frame_o=1 after edge 1.
- Basic scan: digits_i=32'h76543210, blank_i=0, lz_en_i=0.
  - Edges 3-8: DIGIT=8'b11111110, SEG=1111110.
  - Edges 9-10: dark.
  - Edges 11-16: DIGIT=8'b11111101, SEG=0110000.
  - Edges 59-64: DIGIT=8'b01111111, SEG=1110000.
- LZ: digits_i=32'h00000805, lz_en_i=1.
  - Slots 7..3: DIGIT=8'hFF.
  - Slot 2: SEG=1111111.
  - Slot 1: SEG=1111110 (not suppressed).
  - Slot 0: SEG=1011011.
- Buffering: change digits_i from 32'h11111111 to 32'h22222222 at cycle 20. Required: all slots show 0110000 until the edge-65 load; frame_o pulses once after edge 65; slot 0 then shows 1101101 from edge 67.
- Blank/hex: digits_i=32'h000000F3, blank_i=8'h01. Required: slot 0 dark; slot 1 shows DIGIT=8'b11111101, SEG=1000111.
- Reset during slot 3: pull rst low mid-slot. Required: DIGIT=8'hFF and SEG=0 before the next edge; after release, scanning restarts at slot 0 with frame_o after edge 1.
